stream_demux_1x2: RTL and testbench

STREAM_DEMUX_1X2 -- requirements
Module: stream_demux_1x2

---
 rtl/stream_demux_1x2.sv | 133 +++++++++++++
 tb/tb_stream_demux_1x2.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1x2.sv
// One-input, two-output stream demultiplexer with an in-order FIFO and head-of-line blocking.
// Define STREAM_DEMUX_SKID_EN for a 2-deep buffer with a registered in_ready_o.
module stream_demux_1x2 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_sel_i,
    output logic                  out0_valid_o,
    input  logic                  out0_ready_i,
    output logic [DATA_WIDTH-1:0] out0_data_o,
    output logic                  out1_valid_o,
    input  logic                  out1_ready_i,
    output logic [DATA_WIDTH-1:0] out1_data_o,
    output logic [1:0]            count_o
);

    // Encoding equals occupancy so count_o is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sel;
    } beat_t;

    state_e state_q, state_d;
    beat_t  head_q, head_d;
    beat_t  in_beat;
    logic   push, pop;

`ifdef STREAM_DEMUX_SKID_EN
    beat_t tail_q, tail_d;
    logic  in_ready_q, in_ready_d;
`else
    logic  ready_en_q;
`endif

    assign in_beat = {in_data_i, in_sel_i};

    assign out0_valid_o = (state_q != EMPTY) && !head_q.sel;
    assign out1_valid_o = (state_q != EMPTY) &&  head_q.sel;
    assign out0_data_o  = out0_valid_o ? head_q.data : '0;
    assign out1_data_o  = out1_valid_o ? head_q.data : '0;
    assign count_o      = state_q;

    assign pop  = (out0_valid_o && out0_ready_i) || (out1_valid_o && out1_ready_i);
    assign push = in_valid_i && in_ready_o;

`ifdef STREAM_DEMUX_SKID_EN
    assign in_ready_o = in_ready_q;
`else
    // The single slot frees up in the same cycle the head leaves.
    assign in_ready_o = ready_en_q && ((state_q == EMPTY) || pop);
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        head_d  = head_q;
`ifdef STREAM_DEMUX_SKID_EN
        tail_d  = tail_q;
`endif
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    head_d  = in_beat;
                end
            end
            ONE: begin
                if (pop && push) begin
                    head_d = in_beat;
                end else if (pop) begin
                    state_d = EMPTY;
                    head_d  = '0;
`ifdef STREAM_DEMUX_SKID_EN
                end else if (push) begin
                    state_d = TWO;
                    tail_d  = in_beat;
`endif
                end
            end
`ifdef STREAM_DEMUX_SKID_EN
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = tail_q;
                    tail_d  = '0;
                end
            end
`endif
            default: begin
                state_d = EMPTY;
                head_d  = '0;
            end
        endcase
`ifdef STREAM_DEMUX_SKID_EN
        in_ready_d = (state_d != TWO);
`endif
    end

    // NOTE: the stored beats are reset too, so a discarded beat can never reappear on an output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= EMPTY;
            head_q     <= '0;
`ifdef STREAM_DEMUX_SKID_EN
            tail_q     <= '0;
            in_ready_q <= 1'b0;
`else
            ready_en_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            head_q     <= head_d;
`ifdef STREAM_DEMUX_SKID_EN
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
`else
            ready_en_q <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_stream_demux_1x2.sv
// Self-checking bench for stream_demux_1x2: a queue model of the buffer is compared against
// the DUT every cycle, half a period after the active edge.
module tb_stream_demux_1x2;

    localparam int DW = 8;
`ifdef STREAM_DEMUX_SKID_EN
    localparam bit SKID  = 1'b1;
    localparam int DEPTH = 2;
`else
    localparam bit SKID  = 1'b0;
    localparam int DEPTH = 1;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          in_sel_i;
    logic          out0_valid_o;
    logic          out0_ready_i;
    logic [DW-1:0] out0_data_o;
    logic          out1_valid_o;
    logic          out1_ready_i;
    logic [DW-1:0] out1_data_o;
    logic [1:0]    count_o;

    stream_demux_1x2 #(.DATA_WIDTH(DW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .in_sel_i     (in_sel_i),
        .out0_valid_o (out0_valid_o),
        .out0_ready_i (out0_ready_i),
        .out0_data_o  (out0_data_o),
        .out1_valid_o (out1_valid_o),
        .out1_ready_i (out1_ready_i),
        .out1_data_o  (out1_data_o),
        .count_o      (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] data;
        logic          sel;
    } beat_t;

    beat_t model_q[$];
    bit    started;
    int    n_checks;
    int    n_fail;
    bit    m_push, m_pop;

    // View layout: {count[20:19], v0[18], v1[17], d0[16:9], d1[8:1], ready[0]}
    logic [20:0] exp_v, act_v;

    function automatic logic [20:0] model_view();
        int            size = model_q.size();
        logic          v0 = 1'b0, v1 = 1'b0, drain, rdy;
        logic [DW-1:0] d0 = '0, d1 = '0;
        if (size > 0) begin
            v0 = !model_q[0].sel;
            v1 =  model_q[0].sel;
            d0 = v0 ? model_q[0].data : '0;
            d1 = v1 ? model_q[0].data : '0;
        end
        drain = (v0 && out0_ready_i) || (v1 && out1_ready_i);
        // A free slot, or (single-slot build only) the head leaving this very cycle.
        rdy = started && ((size < DEPTH) || (!SKID && drain));
        return {2'(size), v0, v1, d0, d1, rdy};
    endfunction

    function automatic logic [20:0] dut_view();
        return {count_o, out0_valid_o, out1_valid_o, out0_data_o, out1_data_o, in_ready_o};
    endfunction

    // Drive one cycle, snapshot model and DUT views before the edge, then advance the model.
    task automatic step(input logic v, input logic s, input logic [DW-1:0] d,
                        input logic r0, input logic r1);
        @(negedge clk_i);
        in_valid_i   = v;
        in_sel_i     = s;
        in_data_i    = d;
        out0_ready_i = r0;
        out1_ready_i = r1;
        #1;
        exp_v  = model_view();
        act_v  = dut_view();
        m_pop  = (exp_v[18] && r0) || (exp_v[17] && r1);
        m_push = v && exp_v[0];
        @(posedge clk_i);
        if (!rst_i) begin
            if (m_pop) void'(model_q.pop_front());
            if (m_push) model_q.push_back('{data: d, sel: s});
            started = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_i);
        #3;
        act_v = dut_view();
        n_checks++;
        if (act_v !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected %h", act_v, 21'h0);
        end
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < 2) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            else if (i == 2) step(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
            else step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL reset_seq[%0d]: got %h expected %h", i, act_v, exp_v);
            end
        end
        // Holding one beat; reset lands mid-cycle and must clear outputs at once.
        #2 rst_i = 1'b1;
        #1;
        act_v = dut_view();
        n_checks++;
        if (act_v !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h expected %h", act_v, 21'h0);
        end
        model_q.delete();
        started = 1'b0;
        #1 rst_i = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", act_v, exp_v);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (act_v !== {20'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL ready_after_release: got %h expected %h", act_v, {20'h0, 1'b1});
        end
    endtask

    task automatic test_routing();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) step(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
            else if (i == 1) step(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
            else step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            n_checks++;
            if (act_v !== exp_v || (act_v[18] && act_v[17])) begin
                n_fail++;
                $display("FAIL routing[%0d]: got %h expected %h", i, act_v, exp_v);
            end
            if (i == 1) begin
                n_checks++;
                if (act_v[18] !== 1'b1 || act_v[16:9] !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL routing_out0: got v=%b d=%h expected v=1 d=a5", act_v[18], act_v[16:9]);
                end
            end
            if (i == 2) begin
                n_checks++;
                if (act_v[17] !== 1'b1 || act_v[8:1] !== 8'h3C) begin
                    n_fail++;
                    $display("FAIL routing_out1: got v=%b d=%h expected v=1 d=3c", act_v[17], act_v[8:1]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] seen;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) step(1'b1, i[0], 8'(8'h10 + i), 1'b1, 1'b1);
            else step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %h expected %h", i, act_v, exp_v);
            end
            if (i >= 1 && i <= 8) begin
                seen = ((i - 1) % 2 == 1) ? act_v[8:1] : act_v[16:9];
                n_checks++;
                if (seen !== 8'(8'h10 + i - 1) || (i < 8 && act_v[0] !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL b2b_stream[%0d]: got d=%h rdy=%b expected d=%h rdy=1",
                             i, seen, act_v[0], 8'(8'h10 + i - 1));
                end
            end
        end
    endtask

    task automatic test_head_of_line();
        for (int i = 0; i < 10; i++) begin
            if (i == 0) step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
            else if (i <= 5) step(1'b1, 1'b1, 8'hC3, 1'b0, 1'b1);
            else if (i == 6) step(1'b1, 1'b1, 8'hC3, 1'b1, 1'b1);
            else step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL hol[%0d]: got %h expected %h", i, act_v, exp_v);
            end
            if (i >= 1 && i <= 6) begin
                n_checks++;
                if (act_v[17] !== 1'b0 || act_v[18] !== 1'b1 || act_v[16:9] !== 8'h5A) begin
                    n_fail++;
                    $display("FAIL hol_block[%0d]: got v0=%b v1=%b d0=%h expected v0=1 v1=0 d0=5a",
                             i, act_v[18], act_v[17], act_v[16:9]);
                end
            end
        end
    endtask

    task automatic test_full();
        logic rdy_a, rdy_b;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, i[0], 8'(8'h60 + i), 1'b0, 1'b0);
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL full[%0d]: got %h expected %h", i, act_v, exp_v);
            end
        end
        n_checks++;
        if (act_v[20:19] !== 2'(DEPTH) || act_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL full_saturate: got count=%0d rdy=%b expected count=%0d rdy=0",
                     act_v[20:19], act_v[0], DEPTH);
        end
        // Flip the consumer readys mid-cycle: only the single-slot build may react before the edge.
        @(negedge clk_i);
        #1 rdy_a = in_ready_o;
        out0_ready_i = 1'b1;
        out1_ready_i = 1'b1;
        #1 rdy_b = in_ready_o;
        n_checks++;
        if (rdy_a !== 1'b0 || rdy_b !== !SKID) begin
            n_fail++;
            $display("FAIL ready_timing: got %b->%b expected 0->%b", rdy_a, rdy_b, !SKID);
        end
        out0_ready_i = 1'b0;
        out1_ready_i = 1'b0;
        in_valid_i   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
            else if (i == 1) step(1'b1, 1'b0, 8'h22, 1'b0, 1'b1);
            else if (i == 2) step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
            else step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL simul[%0d]: got %h expected %h", i, act_v, exp_v);
            end
            if (i == 2) begin
                n_checks++;
                if (act_v[20:17] !== 4'b0110 || act_v[16:9] !== 8'h22) begin
                    n_fail++;
                    $display("FAIL simul_swap: got cnt/v0/v1=%b d0=%h expected 0110 d0=22",
                             act_v[20:17], act_v[16:9]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    initial begin
        rst_i        = 1'b1;
        in_valid_i   = 1'b0;
        in_sel_i     = 1'b0;
        in_data_i    = '0;
        out0_ready_i = 1'b0;
        out1_ready_i = 1'b0;
        started      = 1'b0;
        n_checks     = 0;
        n_fail       = 0;
        test_reset();
        test_routing();
        test_back_to_back();
        test_head_of_line();
        test_full();
        test_simultaneous();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
